// File: rtl/alarm_link_pkg.sv
// alarm_link_pkg: constants and types shared by both ends of the alarm-state serial link.
// Optional input synchronizers in serial_in are enabled by SERIAL_IN_SYNC_EN.
package alarm_link_pkg;

  localparam int STATE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  localparam logic [STATE_W-1:0] ALARM_OFF   = 4'h0;
  localparam logic [STATE_W-1:0] ALARM_ARMED = 4'h1;
  localparam logic [STATE_W-1:0] ALARM_TRIG  = 4'h2;
  localparam logic [STATE_W-1:0] ALARM_FAULT = 4'hF;

endpackage

// File: rtl/serial_in_if.sv
// serial_in_if: serial line from the transmitter plus the receiver's word outputs.
// master = transmitter/consumer side, slave = serial_in receiver.
interface serial_in_if #(
  parameter int DATA_W = 4
);
  logic              status_send;
  logic              status_out;
  logic [DATA_W-1:0] state;
  logic              state_valid;
  logic              frame_err;
  logic              busy;

  modport master (
    output status_send,
    output status_out,
    input  state,
    input  state_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  status_send,
    input  status_out,
    output state,
    output state_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/serial_in_sync2.sv
// sync2: 1-bit two-flop synchronizer, async active-low reset to 0.
// Used by serial_in only when SERIAL_IN_SYNC_EN is defined.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Two back-to-back flops settle a possibly metastable sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/serial_in.sv
// serial_in: alarm-state serial receiver, MSB-first word reassembly.
// Define SERIAL_IN_SYNC_EN to add 2-flop input synchronizers (+2 cycles).
module serial_in
  import alarm_link_pkg::*;
#(
  parameter int DATA_W = STATE_W
) (
  input logic       clk,
  input logic       rst_n,
  serial_in_if.slave link
);
  localparam int CW = $clog2(DATA_W + 1);

  logic              send;
  logic              din;
  rx_state_e         fsm;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nx;
  logic [DATA_W-1:0] state_q;
  logic              valid_q;
  logic              err_q;

`ifdef SERIAL_IN_SYNC_EN
  sync2 u_sync_send (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (link.status_send),
    .q     (send)
  );

  sync2 u_sync_data (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (link.status_out),
    .q     (din)
  );
`else
  assign send = link.status_send;
  assign din  = link.status_out;
`endif

  assign cnt_nx = cnt + 1'b1;
  assign sh_nx  = DATA_W'({sh, din});

  // Frame FSM: IDLE and RECV both accept a bit when send is high,
  // so a completed frame can be followed by the next MSB at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      state_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (send) begin
        sh <= sh_nx;
        if (cnt_nx == CW'(DATA_W)) begin
          state_q <= sh_nx;
          valid_q <= 1'b1;
          cnt     <= '0;
          fsm     <= IDLE;
        end else begin
          cnt <= cnt_nx;
          fsm <= RECV;
        end
      end else if (fsm == RECV) begin
        err_q <= 1'b1;
        sh    <= '0;
        cnt   <= '0;
        fsm   <= IDLE;
      end
    end
  end

  assign link.state       = state_q;
  assign link.state_valid = valid_q;
  assign link.frame_err   = err_q;
  assign link.busy        = (fsm == RECV);
endmodule

// File: tb/tb_serial_in.sv
// tb_serial_in: directed + random frames against a queue-based line model.
// Model delays inputs by 2 cycles when SERIAL_IN_SYNC_EN is defined.
module tb_serial_in;
  import alarm_link_pkg::*;

  localparam int W = STATE_W;
`ifdef SERIAL_IN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_in_if #(.DATA_W(W)) link ();

  serial_in #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  always #5 clk = ~clk;

  bit         q[$];
  logic [1:0] pipe[$];
  logic [W-1:0] exp_state;
  bit         exp_valid;
  bit         exp_err;
  bit         exp_busy;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pipe.delete();
    exp_state = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_busy  = 1'b0;
  endtask

  task automatic model_edge(bit s, bit d);
    logic [1:0]   e;
    logic [W-1:0] word;
    pipe.push_back({s, d});
    e = (pipe.size() > LAT) ? pipe.pop_front() : 2'b00;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (e[1]) begin
      q.push_back(e[0]);
      if (q.size() == W) begin
        word = '0;
        foreach (q[i]) word = W'((word << 1) | W'(q[i]));
        exp_state = word;
        exp_valid = 1'b1;
        q.delete();
      end
    end else if (q.size() > 0) begin
      exp_err = 1'b1;
      q.delete();
    end
    exp_busy = (q.size() > 0);
  endtask

  task automatic check_all();
    chk("state", link.state, exp_state);
    chk("valid", link.state_valid, exp_valid);
    chk("ferr", link.frame_err, exp_err);
    chk("busy", link.busy, exp_busy);
    chk("excl", link.state_valid & link.frame_err, 0);
  endtask

  task automatic step(bit s, bit d);
    link.status_send = s;
    link.status_out  = d;
    @(posedge clk);
    model_edge(s, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom));
  endtask

  task automatic frame(logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) step(1'b1, w[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_state", link.state, 0);
    chk("rst_valid", link.state_valid, 0);
    chk("rst_ferr", link.frame_err, 0);
    chk("rst_busy", link.busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    link.status_send = 1'b0;
    link.status_out  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();

    frame(4'hA);
    idle(LAT);
    chk("s1_state", link.state, 4'hA);
    idle(2);

    frame(4'h5);
    frame(4'hC);
    idle(LAT);
    chk("s2_state", link.state, 4'hC);
    idle(2);

    frame(4'h3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    idle(LAT + 2);
    chk("s3_state", link.state, 4'h3);
    chk("s3_busy", link.busy, 0);

    idle(20);
    chk("s4_state", link.state, 4'h3);

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    do_reset();
    chk("s5_rst", link.state, 0);
    frame(4'h9);
    idle(LAT);
    chk("s5_state", link.state, 4'h9);

    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    frame(4'hE);
    idle(LAT + 1);
    chk("gap_state", link.state, 4'hE);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        @(negedge clk);
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 8, 1'($urandom));
      end
    end
    idle(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_in.md
Name: serial_in

Overview:
- Receiver end of the alarm-state serial link.
- Samples the `status_send` / `status_out` pair driven by the alarm-state serial transmitter and reassembles each DATA_W-bit state word, MSB first.
- Presents the last good word on a held register with a one-cycle valid strobe, and flags truncated frames.
- Sits on the controller side of the alarm module, feeding state-display and decode logic.

Parameters:
- DATA_W, 4, number of bits per frame (alarm state width).

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- status_send, in, 1: frame-active flag from the transmitter; high while bits are on the line.
- status_out, in, 1: serial data line; one bit per clk while status_send is high.
- state, out, DATA_W: last correctly received word, held until the next good frame.
- state_valid, out, 1: one-cycle pulse when `state` is updated.
- frame_err, out, 1: one-cycle pulse when a frame ends with fewer than DATA_W bits.
- busy, out, 1: high while a frame is partially received.

Behaviour:
- Line protocol, as seen at this block's inputs:
  - Each rising clk edge with status_send=1 carries exactly one data bit on status_out.
  - Bits arrive MSB first: bit DATA_W-1 down to bit 0.
  - A frame is DATA_W consecutive sampled-high cycles.
  - The transmitter may keep status_send high across frames. The next frame's MSB then follows the previous LSB on the next cycle.
  - status_out is don't-care while status_send=0.
- Reset (async assert, sync release):
  - state=0, state_valid=0, frame_err=0, busy=0.
  - Shift register=0, bit counter=0, FSM in IDLE.
- FSM states: IDLE, RECV.
- IDLE:
  - If status_send=1: shift status_out into the shift register LSB (register shifts left), cnt=1, go to RECV.
  - Otherwise hold.
  - For DATA_W=1, the first bit completes the frame immediately: same completion rule as RECV, stay in IDLE.
- RECV, with status_send=1:
  - Shift status_out in, cnt=cnt+1.
  - If the new cnt==DATA_W: load `state` with the assembled word, pulse state_valid, cnt=0, go to IDLE.
  - Going to IDLE gives seamless back-to-back frames, because IDLE accepts the next bit on the very next cycle.
- RECV, with status_send=0:
  - Partial frame: pulse frame_err, discard the shift register, cnt=0, go to IDLE.
  - `state` is unchanged.
- busy = (FSM==RECV).
- Latency: the edge that samples the last bit also registers `state` and `state_valid`. Both are visible in the following cycle, so there is 0 added pipeline stages without the optional feature.
- state_valid and frame_err:
  - Each is high for exactly one cycle.
  - They are never high together.
  - Both are 0 in all other cycles.
- Counter width: clog2(DATA_W+1) bits. cnt never exceeds DATA_W, so no wrap-around.
- Reset mid-frame: the partial word is discarded and `state` returns to 0. No frame_err is generated for it.
- status_send glitch of one cycle low between frames (gap between frames): no error if it falls on a frame boundary.

Optional Feature:
- Macro SERIAL_IN_SYNC_EN.
- When defined:
  - status_send and status_out each pass through a 2-flop synchronizer clocked by clk and reset by rst_n to 0 before entering the FSM.
  - All latencies grow by 2 cycles.
  - Use when the transmitter is in another clock domain or off-chip.
- When undefined: inputs feed the FSM directly; latency as above.

Decomposition:
- Shared package `alarm_link_pkg`:
  - STATE_W=4 constant, used as the DATA_W default by both ends of the link.
  - Enum for rx FSM states (IDLE, RECV).
  - Alarm-state code constants, shared with the transmitter.
- One sub-module, `sync2`: a 1-bit two-flop synchronizer with async active-low reset. It is instantiated twice, only under SERIAL_IN_SYNC_EN.

Test Plan:
- Reset, then status_send high 4 cycles with status_out 1,0,1,0 → state=4'hA, state_valid one cycle after the 4th sample edge, busy high 3 cycles, frame_err stays 0.
- Back-to-back: status_send held high 8 cycles, bits 0,1,0,1,1,1,0,0 → state=4'h5 then 4'hC, state_valid pulses exactly 4 cycles apart, no frame_err.
- Truncated: after a good 4'h3, status_send high 2 cycles then low → frame_err one cycle, state stays 4'h3, busy drops.
- status_out toggling randomly with status_send=0 for 20 cycles → no state_valid, no frame_err, state unchanged.
- rst_n asserted after 2 bits of a frame, released, then full frame 4'h9 → state=0 during reset, no frame_err, next frame yields 4'h9.
- With SERIAL_IN_SYNC_EN, repeat the first scenario → same 4'hA, state_valid delayed by exactly 2 extra cycles.
